// File: rtl/fifo_umbral_if.sv
// fifo_umbral_if
// Interface that groups the push/pop handshake, the threshold settings and
// the status outputs of fifo_umbral.
//   master : producer/consumer side. Drives push, pop, data_in and the
//            thresholds. Observes data_out, valid_out, count, the flags and
//            the errors.
//   slave  : the FIFO itself, with the opposite directions.
interface fifo_umbral_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH:0]   umbral_alto;
  logic [ADDR_WIDTH:0]   umbral_bajo;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic                  almost_empty;
  logic                  error_overflow;
  logic                  error_underflow;

  modport master (
    output push, pop, data_in, umbral_alto, umbral_bajo,
    input  data_out, valid_out, count, full, almost_full, empty,
           almost_empty, error_overflow, error_underflow
  );

  modport slave (
    input  push, pop, data_in, umbral_alto, umbral_bajo,
    output data_out, valid_out, count, full, almost_full, empty,
           almost_empty, error_overflow, error_underflow
  );
endinterface

// File: rtl/fifo_umbral.sv
// fifo_umbral
// Synchronous FIFO with programmable almost-full / almost-empty thresholds
// and sticky overflow / underflow error flags.
// Ports:
//   clk    : single clock; all state updates on the rising edge.
//   reset  : asynchronous reset, active low.
//   bus    : fifo_umbral_if.slave
//            push/data_in  write request and word
//            pop           read request; data_out/valid_out one cycle later
//            umbral_alto/umbral_bajo  thresholds in words
//            count, full, almost_full, empty, almost_empty  occupancy status
//            error_overflow/error_underflow  sticky until reset
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input logic          clk,
  input logic          reset,
  fifo_umbral_if.slave bus
);

  localparam int                DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1;
  logic                  err_ovf;
  logic                  err_unf;

  logic pop_acc;
  logic push_acc;

  // No bypass: an empty FIFO rejects a pop even if a push lands this cycle.
  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  assign pop_acc  = bus.pop && (count_q != '0);
  assign push_acc = bus.push && ((count_q < FULL_CNT) || pop_acc);

  // Storage is not reset; a write while full-with-pop reuses the slot that
  // the pop reads, and the nonblocking read still returns the old word.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      // Read stage -> data_p1 / vld_p1
      vld_p1 <= pop_acc;
      if (pop_acc) begin
        data_p1 <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end

      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (bus.push && !push_acc) begin
        err_ovf <= 1'b1;
      end
      if (bus.pop && !pop_acc) begin
        err_unf <= 1'b1;
      end
    end
  end

  assign bus.data_out        = data_p1;
  assign bus.valid_out       = vld_p1;
  assign bus.count           = count_q;
  assign bus.error_overflow  = err_ovf;
  assign bus.error_underflow = err_unf;

  // Flags derive from the registered count, so they move with count.
  assign bus.empty        = (count_q == '0);
  assign bus.full         = (count_q == FULL_CNT);
  assign bus.almost_empty = (count_q != '0) && (count_q <= bus.umbral_bajo);
  assign bus.almost_full  = (count_q != FULL_CNT) && (count_q >= bus.umbral_alto);

endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral
// Directed bench for fifo_umbral (DEPTH=4, umbral_alto=3, umbral_bajo=1).
module tb_fifo_umbral;

  localparam int DW = 6;
  localparam int AW = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fifo_umbral_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ps, input logic pp, input logic [DW-1:0] d);
    bus.push    = ps;
    bus.pop     = pp;
    bus.data_in = d;
  endtask

  task automatic check_flags(input string tag, input logic [2:0] cnt,
                             input logic e, input logic ae, input logic af,
                             input logic f);
    check({tag, ".count"}, {5'd0, bus.count}, {5'd0, cnt});
    check({tag, ".flags"},
          {4'd0, bus.empty, bus.almost_empty, bus.almost_full, bus.full},
          {4'd0, e, ae, af, f});
  endtask

  initial begin
    logic [DW-1:0] exp_q [$];
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.umbral_alto = 3'd3;
    bus.umbral_bajo = 3'd1;
    drive(1'b0, 1'b0, '0);

    // Reset, then idle
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_flags("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset.data_out", {2'b0, bus.data_out}, 8'h00);
    check("reset.valid", {7'd0, bus.valid_out}, 8'h00);
    check("reset.errors", {6'd0, bus.error_overflow, bus.error_underflow}, 8'h00);

    // Fill with 1..4
    drive(1'b1, 1'b0, 6'h01); tick();
    check_flags("push1", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 6'h02); tick();
    check_flags("push2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 6'h03); tick();
    check_flags("push3", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 6'h04); tick();
    check_flags("push4", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);

    // Overflow
    drive(1'b1, 1'b0, 6'h3F); tick();
    check("ovf.err", {7'd0, bus.error_overflow}, 8'h01);
    check_flags("ovf", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, '0); tick();
    check("ovf.sticky", {7'd0, bus.error_overflow}, 8'h01);

    // Drain: 1..4 in order, 0x3F never appears
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, '0); tick();
      check($sformatf("drain%0d.data", i), {2'b0, bus.data_out}, 8'(i));
      check($sformatf("drain%0d.valid", i), {7'd0, bus.valid_out}, 8'h01);
      check($sformatf("drain%0d.count", i), {5'd0, bus.count}, 8'(4 - i));
    end
    check_flags("drained", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0); tick();
    check("idle.valid", {7'd0, bus.valid_out}, 8'h00);
    check("idle.hold", {2'b0, bus.data_out}, 8'h04);

    // Underflow
    check("pre_unf.err", {7'd0, bus.error_underflow}, 8'h00);
    drive(1'b0, 1'b1, '0); tick();
    check("unf.err", {7'd0, bus.error_underflow}, 8'h01);
    check("unf.count", {5'd0, bus.count}, 8'h00);
    check("unf.valid", {7'd0, bus.valid_out}, 8'h00);

    // Push+pop on empty: no bypass
    drive(1'b1, 1'b1, 6'h15); tick();
    check("nobypass.count", {5'd0, bus.count}, 8'h01);
    check("nobypass.valid", {7'd0, bus.valid_out}, 8'h00);
    drive(1'b0, 1'b1, '0); tick();
    check("nobypass.data", {2'b0, bus.data_out}, 8'h15);
    check("nobypass.vld", {7'd0, bus.valid_out}, 8'h01);
    check("nobypass.cnt0", {5'd0, bus.count}, 8'h00);

    // Clear errors with a reset pulse between edges
    drive(1'b0, 1'b0, '0);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    check("clr.errors", {6'd0, bus.error_overflow, bus.error_underflow}, 8'h00);

    // Fill, then 5 simultaneous push/pop to wrap pointers
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 6'(8'h21 + i)); tick();
      exp_q.push_back(6'(8'h21 + i));
    end
    check_flags("refill", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 6'(8'h2A + i)); tick();
      exp_q.push_back(6'(8'h2A + i));
      check($sformatf("swap%0d.data", i), {2'b0, bus.data_out}, {2'b0, exp_q.pop_front()});
      check($sformatf("swap%0d.valid", i), {7'd0, bus.valid_out}, 8'h01);
      check_flags($sformatf("swap%0d", i), 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("swap.noovf", {7'd0, bus.error_overflow}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, '0); tick();
      check($sformatf("wrapdrain%0d", i), {2'b0, bus.data_out}, {2'b0, exp_q.pop_front()});
    end
    check_flags("wrapdrained", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Set underflow, bring count to 2
    drive(1'b0, 1'b1, '0); tick();
    check("unf2.err", {7'd0, bus.error_underflow}, 8'h01);
    drive(1'b1, 1'b0, 6'h31); tick();
    drive(1'b1, 1'b0, 6'h32); tick();
    drive(1'b0, 1'b0, '0);
    check_flags("two", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Threshold extremes: alto=0 and bajo>=DEPTH
    bus.umbral_alto = 3'd0;
    bus.umbral_bajo = 3'd4;
    #1;
    check_flags("extreme", 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.umbral_alto = 3'd3;
    bus.umbral_bajo = 3'd1;
    #1;

    // Asynchronous reset mid-cycle with count=2
    reset = 1'b0;
    #1;
    check_flags("async_rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("async_rst.errors", {6'd0, bus.error_overflow, bus.error_underflow}, 8'h00);
    check("async_rst.data_out", {2'b0, bus.data_out}, 8'h00);
    tick();
    check("held_rst.count", {5'd0, bus.count}, 8'h00);

    // Release: first edge with reset high accepts the push
    reset = 1'b1;
    drive(1'b1, 1'b0, 6'h2C); tick();
    check("release.count", {5'd0, bus.count}, 8'h01);
    drive(1'b0, 1'b1, '0); tick();
    check("release.data", {2'b0, bus.data_out}, 8'h2C);
    drive(1'b0, 1'b0, '0); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_umbral.md
# fifo_umbral

Synchronous FIFO with programmable occupancy thresholds that produces the `almost_full`, `full`, `almost_empty` and `empty` status flags consumed by the flow-control state machine. It sits directly upstream of that state machine and buffers data words between a producer (push side) and a consumer (pop side). Overflow and underflow attempts are reported through sticky error outputs.

## Interface
- `DATA_WIDTH`, 6: width of one data word.
- `ADDR_WIDTH`, 2: pointer width; depth `DEPTH = 2**ADDR_WIDTH`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `push`  in  1  write request for `data_in` this cycle.
- `pop`  in  1  read request this cycle.
- `data_in`  in  DATA_WIDTH  word to write.
- `umbral_alto`  in  ADDR_WIDTH+1  almost-full threshold, in words.
- `umbral_bajo`  in  ADDR_WIDTH+1  almost-empty threshold, in words.
- `data_out`  out  DATA_WIDTH  registered read data.
- `valid_out`  out  1  `data_out` holds a newly popped word (1-cycle pulse).
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `full`, `almost_full`, `empty`, `almost_empty`  out  1  occupancy flags.
- `error_overflow`, `error_underflow`  out  1  sticky error flags.

## Operation
- Storage: DEPTH x DATA_WIDTH register array, write pointer `wr_ptr` and read pointer `rd_ptr` (ADDR_WIDTH bits each), and a `count` register. Pointers wrap modulo DEPTH. The array is not reset.
- An accepted push writes `data_in` at `wr_ptr` and increments `wr_ptr`.
- An accepted pop loads `mem[rd_ptr]` into `data_out`, sets `valid_out`=1 and increments `rd_ptr`. Without an accepted pop, `valid_out`=0 and `data_out` holds its value.
- Acceptance rules:
  - Push is accepted when `count < DEPTH`, or when `count == DEPTH` and a pop is accepted in the same cycle.
  - Pop is accepted when `count > 0`.
  - No bypass: a pop with `count == 0` is rejected even if a push occurs in the same cycle.
- Count update: `count` goes +1 on push only, -1 on pop only, and is unchanged when both are accepted.
- Flags are combinational functions of registered `count` and the thresholds:
  - `empty` = (count == 0)
  - `full` = (count == DEPTH)
  - `almost_empty` = (count != 0) && (count <= umbral_bajo)
  - `almost_full` = (count != DEPTH) && (count >= umbral_alto)
  - Comparisons are unsigned at ADDR_WIDTH+1 bits.
  - `umbral_alto` = 0 asserts `almost_full` whenever the FIFO is not full; `umbral_bajo` >= DEPTH asserts `almost_empty` whenever the FIFO is not empty.
- Errors:
  - A rejected push sets `error_overflow`; the data is dropped and no state changes.
  - A rejected pop sets `error_underflow`; `rd_ptr` is unchanged.
  - Both errors stay set until reset.
- Reset (asynchronous, `reset`=0):
  - Pointers, `count`, `data_out`, `valid_out` and both errors are cleared to 0 immediately.
  - Resulting flags: `empty`=1, `full`=0, `almost_full`=0, `almost_empty`=0.
  - Reset asserted mid-operation discards all contents.
  - Reset release is taken synchronously: the first push is accepted on the first rising edge with `reset`=1.

## Timing
- Write latency: a word pushed at edge N can be popped at edge N+1 and appears on `data_out` after edge N+1.
- Read latency: one cycle from the `pop` sample edge to valid `data_out` and `valid_out`.
- Flags change in the same cycle as `count`, i.e. directly after the edge that accepted the push or pop.
- The downstream state machine samples the flags on the next edge.

## Test plan
- Configuration for all scenarios: DEPTH=4, `umbral_alto`=3, `umbral_bajo`=1.
- Reset then idle -> `empty`=1, all other flags 0, `count`=0, `data_out`=0, errors 0.
- Push 0x01, 0x02, 0x03, 0x04 on consecutive cycles -> `count` goes 1,2,3,4:
  - `almost_empty`=1 at count 1.
  - `almost_full`=1 at count 3.
  - At count 4: `full`=1 and `almost_full`=0.
- From full, push 0x3F without pop -> `error_overflow`=1 and stays set, `count`=4, 0x3F is never read. Then pop x4 -> `data_out` 0x01, 0x02, 0x03, 0x04 with `valid_out` high each following cycle, ending with `empty`=1.
- Pop on empty -> `error_underflow`=1, `count`=0, `valid_out`=0. Simultaneous push 0x15 and pop on empty -> `count`=1 and the next pop returns 0x15.
- Full FIFO with simultaneous push 0x2A and pop -> oldest word is output, `count` stays 4, no overflow. Repeat 5 times to exercise pointer wrap; data order is preserved.
- Assert `reset`=0 mid-cycle with `count`=2 -> outputs clear immediately without a clock edge: `empty`=1 and both errors 0.
